// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the four-requester round-robin bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [0:0] {
    IDLE,
    OWNED
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               hit,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Walk from the farthest offset down so the closest match to ptr wins last.
  always_comb begin
    hit  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + ID_W'(i);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four requesters with a registered shared data path.
// Optional hold-limit preemption is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [DW-1:0]        din0,
  input  logic [DW-1:0]        din1,
  input  logic [DW-1:0]        din2,
  input  logic [DW-1:0]        din3,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_W-1:0]      sel,
  output logic                 busy,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid,
  output logic                 timeout
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    sel_q, sel_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;

  logic [NUM_REQ-1:0] pick_req;
  logic               pick_hit;
  logic [ID_W-1:0]    pick_idx;
  logic               take, go_idle, hold_limit, limit_hit;
  logic [DW-1:0]      din_sel;

  // Current owner is masked out so the picker only ever offers a different requester.
  assign pick_req = req & ~grant_q;

  rr_pick u_rr_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    take       = 1'b0;
    go_idle    = 1'b0;
    hold_limit = 1'b0;
    unique case (state_q)
      IDLE: take = pick_hit;
      OWNED: begin
        if (!req[sel_q]) begin
          take    = pick_hit;
          go_idle = !pick_hit;
        end else begin
          hold_limit = limit_hit && pick_hit;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (take || hold_limit) begin
      state_d = OWNED;
      grant_d = id_to_onehot(pick_idx);
      sel_d   = pick_idx;
      ptr_d   = pick_idx + ID_W'(1);
    end else if (go_idle) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end

  always_comb begin
    din_sel = din0;
    unique case (sel_q)
      2'd0: din_sel = din0;
      2'd1: din_sel = din1;
      2'd2: din_sel = din2;
      2'd3: din_sel = din3;
      default: din_sel = din0;
    endcase
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = |grant_q;
    if (|grant_q) begin
      dout_d = din_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      sel_q        <= '0;
      ptr_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign limit_hit = (hold_cnt_q >= 8'(HOLD_MAX));

  // Counter saturates at the limit so a late competing request preempts on its first cycle.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = hold_limit;
    if (take || hold_limit) begin
      hold_cnt_d = 8'd1;
    end else if (go_idle) begin
      hold_cnt_d = 8'd0;
    end else if ((state_q == OWNED) && (hold_cnt_q < 8'(HOLD_MAX))) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic [7:0] unused_hold_max;

  assign unused_hold_max = 8'(HOLD_MAX);
  assign limit_hit       = 1'b0;
  assign timeout         = 1'b0;
`endif

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign busy       = |grant_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: cycle model plus directed literal scenarios.
module tb_bus_arbiter;

  localparam int DW       = 8;
  localparam int HOLD_MAX = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req   = 4'b0000;
  logic [DW-1:0] din0  = 8'h10;
  logic [DW-1:0] din1  = 8'h21;
  logic [DW-1:0] din2  = 8'h32;
  logic [DW-1:0] din3  = 8'h43;
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          timeout;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .DW       (DW),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .grant      (grant),
    .sel        (sel),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .timeout    (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner as an integer, -1 when the bus is free.
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_cnt   = 0;
  logic [1:0]    m_sel   = 2'd0;
  logic [DW-1:0] m_dout  = '0;
  logic          m_dv    = 1'b0;
  logic          m_to    = 1'b0;

  function automatic logic [DW-1:0] din_of(input int k);
    case (k)
      0: return din0;
      1: return din1;
      2: return din2;
      default: return din3;
    endcase
  endfunction

  function automatic int rr_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] others;
    int         w;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 2'd0;
      m_dout  = '0; m_dv = 1'b0; m_to = 1'b0;
    end else begin
      if (m_owner >= 0) begin
        m_dout = din_of(m_owner);
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      m_to   = 1'b0;
      others = req;
      if (m_owner >= 0) others[m_owner] = 1'b0;
      w = -1;
      if (m_owner < 0) begin
        if (req != 4'b0) w = rr_from(req, m_ptr);
      end else if (!req[m_owner]) begin
        if (others != 4'b0) w = rr_from(others, m_ptr);
        else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (m_cnt >= HOLD_MAX && others != 4'b0) begin
        w    = rr_from(others, m_ptr);
        m_to = 1'b1;
      end else if (m_cnt < HOLD_MAX) begin
        m_cnt++;
      end
`endif
      if (w >= 0) begin
        m_owner = w;
        m_sel   = 2'(w);
        m_ptr   = (w + 1) % 4;
        m_cnt   = 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_g;
    exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("cmp_grant", 32'(grant), 32'(exp_g));
    chk("cmp_sel", 32'(sel), 32'(m_sel));
    chk("cmp_busy", 32'(busy), 32'(exp_g != 4'b0000));
    chk("cmp_dout", 32'(dout), 32'(m_dout));
    chk("cmp_dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("cmp_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1100,
                             4'b1100, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] rr_exp [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001};
  logic [3:0] mix_req [13] = '{4'b1000, 4'b1001, 4'b1001, 4'b0001, 4'b0110, 4'b0110,
                               4'b0010, 4'b0000, 4'b1111, 4'b0111, 4'b0011, 4'b0001,
                               4'b0000};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    step(2);
    rst_n = 1'b1;

    // Two simultaneous requesters, then hand-over with no gap.
    do_reset();
    req = 4'b0101;
    step(1);
    chk("s1_first_grant", 32'(grant), 32'h1);
    req = 4'b0100;
    step(1);
    chk("s1_second_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    step(1);
    chk("s1_idle_grant", 32'(grant), 32'h0);
    chk("s1_idle_sel_hold", 32'(sel), 32'h2);
    chk("s1_idle_busy", 32'(busy), 32'h0);
    step(1);
    chk("s1_idle_dv", 32'(dout_valid), 32'h0);

    // All four requesting, each releasing after two grant cycles.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req = rr_req[i];
      step(1);
      chk($sformatf("s2_rr_grant_%0d", i), 32'(grant), 32'(rr_exp[i]));
    end
    req = 4'b0000;
    step(2);

    // Data path latency.
    do_reset();
    din2 = 8'hA5;
    req  = 4'b0100;
    step(1);
    chk("s3_grant", 32'(grant), 32'h4);
    chk("s3_sel", 32'(sel), 32'h2);
    chk("s3_dv_early", 32'(dout_valid), 32'h0);
    step(1);
    chk("s3_dout", 32'(dout), 32'hA5);
    chk("s3_dv", 32'(dout_valid), 32'h1);
    req = 4'b0000;
    step(2);

`ifdef BUS_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0010;
    step(1);
    chk("s4_grant1", 32'(grant), 32'h2);
    req = 4'b1010;
    step(7);
    chk("s4_last_owned", 32'(grant), 32'h2);
    chk("s4_no_pulse_yet", 32'(timeout), 32'h0);
    step(1);
    chk("s4_preempt", 32'(grant), 32'h8);
    chk("s4_pulse", 32'(timeout), 32'h1);
    step(1);
    chk("s4_pulse_end", 32'(timeout), 32'h0);
    req = 4'b0000;
    step(3);
`else
    do_reset();
    req = 4'b0010;
    step(1);
    req = 4'b1010;
    step(20);
    chk("s4_hold_forever", 32'(grant), 32'h2);
    chk("s4_no_timeout", 32'(timeout), 32'h0);
    req = 4'b0000;
    step(3);
`endif

    // Mixed vectors with changing data words; the model covers every cycle.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req  = mix_req[i];
      din0 = 8'($urandom); din1 = 8'($urandom);
      din2 = 8'($urandom); din3 = 8'($urandom);
      step(1);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0010;
    step(2);
    chk("s5_dv_before", 32'(dout_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_grant", 32'(grant), 32'h0);
    chk("s5_async_busy", 32'(busy), 32'h0);
    chk("s5_async_dv", 32'(dout_valid), 32'h0);
    chk("s5_async_dout", 32'(dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    step(1);
    chk("s5_ptr_restart", 32'(grant), 32'h1);
    req = 4'b0000;
    step(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
